// File: rtl/fp_mult_pkg.sv
// rtl/fp_mult_pkg.sv - shared types, status bit indices and helpers for the fp_mult pipeline
//
// Contents:
//   round_values   rounding mode selector for fp_mult
//   STATUS_*       bit positions inside the 8-bit status word ([7:6] always 0)
//   QNAN           canonical quiet NaN returned for invalid operations
//   lzc48          leading-zero count of a 48-bit significand product
package fp_mult_pkg;

  typedef enum logic [2:0] {
    IEEE_near    = 3'd0,
    IEEE_zero    = 3'd1,
    IEEE_pos_inf = 3'd2,
    IEEE_neg_inf = 3'd3,
    near_up      = 3'd4,
    away_zero    = 3'd5
  } round_values;

  localparam int STATUS_ZERO    = 0;
  localparam int STATUS_INF     = 1;
  localparam int STATUS_NAN     = 2;
  localparam int STATUS_TINY    = 3;
  localparam int STATUS_HUGE    = 4;
  localparam int STATUS_INEXACT = 5;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // Scans low to high so the highest set bit decides; all-zero input gives 48.
  function automatic logic [5:0] lzc48(input logic [47:0] v);
    lzc48 = 6'd48;
    for (int i = 0; i < 48; i++) begin
      if (v[i]) lzc48 = 6'(47 - i);
    end
  endfunction

endpackage

// File: rtl/fp_mult.sv
// rtl/fp_mult.sv - combinational IEEE-754 single-precision multiplier core
//
// Parameters:
//   round    rounding mode (round_values)
// Ports:
//   a, b     in   32  operands
//   z        out  32  rounded product
//   status   out  8   [0] zero [1] inf [2] nan [3] tiny [4] huge [5] inexact
module fp_mult
  import fp_mult_pkg::*;
#(
  parameter round_values round = IEEE_near
) (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] z,
  output logic [7:0]  status
);

  logic        sign, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [7:0]  ea, eb, ebase;
  logic [23:0] ma, mb;
  logic [47:0] prod, norm;
  logic [95:0] wide;
  logic [5:0]  lz;
  logic        g, s, inc, to_inf;
  logic [31:0] rounded;
  int          e, sh;

  always_comb begin
    sign   = a[31] ^ b[31];
    a_nan  = (&a[30:23]) & (|a[22:0]);
    b_nan  = (&b[30:23]) & (|b[22:0]);
    a_inf  = (&a[30:23]) & ~(|a[22:0]);
    b_inf  = (&b[30:23]) & ~(|b[22:0]);
    a_zero = ~(|a[30:0]);
    b_zero = ~(|b[30:0]);

    // Subnormals use exponent 1 with no hidden bit.
    ea = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
    eb = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
    ma = {|a[30:23], a[22:0]};
    mb = {|b[30:23], b[22:0]};

    prod = 48'(ma) * 48'(mb);
    lz   = lzc48(prod);
    norm = prod << lz;
    // Biased exponent of the result once the leading one sits at bit 47.
    e    = int'(ea) + int'(eb) - 126 - int'(lz);

    // Results below the normal range are shifted right into subnormal form;
    // the shifted-out bits feed the sticky bit.
    sh    = (e > 0) ? 0 : ((1 - e > 63) ? 63 : 1 - e);
    wide  = {norm, 48'd0} >> sh;
    g     = wide[71];
    s     = |wide[70:0];
    // The hidden bit (wide[95]) is added on top of ebase, so normal results
    // use e-1 here and subnormals use 0.
    ebase = (e > 0) ? 8'(e - 1) : 8'd0;

    case (round)
      IEEE_near:    inc = g & (s | wide[72]);
      IEEE_zero:    inc = 1'b0;
      IEEE_pos_inf: inc = ~sign & (g | s);
      IEEE_neg_inf: inc = sign & (g | s);
      near_up:      inc = g;
      away_zero:    inc = g | s;
      default:      inc = g & (s | wide[72]);
    endcase

    to_inf = (round == IEEE_near) || (round == near_up) || (round == away_zero) ||
             ((round == IEEE_pos_inf) && !sign) || ((round == IEEE_neg_inf) && sign);

    // A rounding carry propagates into the exponent field, including up to inf.
    rounded = {1'b0, ebase, 23'd0} + {8'd0, wide[95:72]} + {31'd0, inc};
    z       = {sign, rounded[30:0]};

    status                 = '0;
    status[STATUS_ZERO]    = (rounded[30:0] == 31'd0);
    status[STATUS_TINY]    = (e <= 0);
    status[STATUS_HUGE]    = (rounded[30:23] == 8'hFF);
    status[STATUS_INEXACT] = g | s;

    if (e >= 255) begin
      z                      = to_inf ? {sign, 8'hFF, 23'd0} : {sign, 8'hFE, 23'h7F_FFFF};
      status                 = '0;
      status[STATUS_HUGE]    = 1'b1;
      status[STATUS_INEXACT] = 1'b1;
    end

    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      z                  = QNAN;
      status             = '0;
      status[STATUS_NAN] = 1'b1;
    end else if (a_inf || b_inf) begin
      z                  = {sign, 8'hFF, 23'd0};
      status             = '0;
      status[STATUS_INF] = 1'b1;
    end else if (a_zero || b_zero) begin
      z                   = {sign, 31'd0};
      status              = '0;
      status[STATUS_ZERO] = 1'b1;
    end
  end

endmodule

// File: rtl/fp_mult_pipe.sv
// rtl/fp_mult_pipe.sv - flow-controlled pipelined wrapper around fp_mult
//
// Parameters:
//   round      rounding mode passed to fp_mult
//   STAGES     retiming stages after the core, 1..8
//   TAG_W      width of the user tag
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid/in_ready         input handshake for a, b, in_tag
//   out_valid/out_ready       output handshake for z, status, out_tag
//   sticky, clr_sticky        accumulated status of delivered results, sync clear
//   occupancy                 number of valid pipeline registers (0..STAGES+1)
module fp_mult_pipe
  import fp_mult_pkg::*;
#(
  parameter round_values round  = IEEE_near,
  parameter int          STAGES = 2,
  parameter int          TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      a,
  input  logic [31:0]      b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      z,
  output logic [7:0]       status,
  output logic [TAG_W-1:0] out_tag,
  output logic [7:0]       sticky,
  input  logic             clr_sticky,
  output logic [3:0]       occupancy
);

  typedef struct packed {
    logic             valid;
    logic [31:0]      z;
    logic [7:0]       status;
    logic [TAG_W-1:0] tag;
  } stage_t;

  if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
    $error("fp_mult_pipe: STAGES must be in 1..8");
  end

  logic             s0_valid;
  logic [31:0]      s0_a, s0_b;
  logic [TAG_W-1:0] s0_tag;
  logic [31:0]      core_z;
  logic [7:0]       core_status;
  stage_t           stg [1:STAGES];
  logic [STAGES:0]  adv;
  logic             adv_run;

  // A stage may load when it is empty or its contents move on, so empty
  // stages upstream of a stall still fill.
  always_comb begin
    adv         = '0;
    adv_run     = ~stg[STAGES].valid | out_ready;
    adv[STAGES] = adv_run;
    for (int i = STAGES - 1; i >= 1; i--) begin
      adv_run = ~stg[i].valid | adv_run;
      adv[i]  = adv_run;
    end
    adv[0] = ~s0_valid | adv_run;
  end

  assign in_ready = adv[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_valid <= 1'b0;
      s0_a     <= '0;
      s0_b     <= '0;
      s0_tag   <= '0;
    end else if (adv[0]) begin
      s0_valid <= in_valid;
      s0_a     <= a;
      s0_b     <= b;
      s0_tag   <= in_tag;
    end
  end

  fp_mult #(.round(round)) u_core (
    .a      (s0_a),
    .b      (s0_b),
    .z      (core_z),
    .status (core_status)
  );

  for (genvar i = 1; i <= STAGES; i++) begin : g_stage
    if (i == 1) begin : g_head
      always_ff @(posedge clk or posedge rst) begin
        if (rst) stg[i] <= '0;
        else if (adv[i]) stg[i] <= '{valid: s0_valid, z: core_z, status: core_status, tag: s0_tag};
      end
    end else begin : g_body
      always_ff @(posedge clk or posedge rst) begin
        if (rst) stg[i] <= '0;
        else if (adv[i]) stg[i] <= stg[i-1];
      end
    end
  end

  assign out_valid = stg[STAGES].valid;
  assign z         = stg[STAGES].z;
  assign status    = stg[STAGES].status;
  assign out_tag   = stg[STAGES].tag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sticky <= '0;
    else if (clr_sticky) sticky <= '0;
    else if (out_valid && out_ready) sticky <= sticky | status;
  end

  always_comb begin
    occupancy = {3'd0, s0_valid};
    for (int i = 1; i <= STAGES; i++) begin
      occupancy = occupancy + {3'd0, stg[i].valid};
    end
  end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// tb/tb_fp_mult_pipe.sv - scoreboard bench for fp_mult_pipe
module tb_fp_mult_pipe;
  import fp_mult_pkg::*;

  localparam int STAGES = 2;
  localparam int TAG_W  = 4;
  localparam int NV     = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b1;
  logic             clr_sticky = 1'b0;
  logic [31:0]      a = '0;
  logic [31:0]      b = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             in_ready, out_valid;
  logic [31:0]      z;
  logic [7:0]       status, sticky;
  logic [TAG_W-1:0] out_tag;
  logic [3:0]       occupancy;

  fp_mult_pipe #(.round(IEEE_near), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .z          (z),
    .status     (status),
    .out_tag    (out_tag),
    .sticky     (sticky),
    .clr_sticky (clr_sticky),
    .occupancy  (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      z;
    logic [7:0]       st;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur_exp;
  exp_t        e_mon;
  int          n_checks = 0;
  int          n_fail = 0;
  int          delivered = 0;
  int          base;
  int          cycles;
  logic        prod_done;
  logic [31:0] va [NV];
  logic [31:0] vb [NV];
  logic [31:0] vz [NV];
  logic [7:0]  vs [NV];

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [31:0] ai, input logic [31:0] bi,
                         input logic [31:0] zi, input logic [7:0] si);
    va[i] = ai; vb[i] = bi; vz[i] = zi; vs[i] = si;
  endtask

  task automatic send_op(input int idx, input logic [TAG_W-1:0] tag);
    int n = 0;
    a = va[idx];
    b = vb[idx];
    in_tag = tag;
    cur_exp = '{z: vz[idx], st: vs[idx], tag: tag};
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_value("accept", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < max) begin
      @(posedge clk); #1;
      n++;
    end
    check_value("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_out_valid(input int max);
    int n = 0;
    while (!out_valid && n < max) begin
      @(posedge clk); #1;
      n++;
    end
    check_value("out_valid_wait", 32'(out_valid), 32'd1);
  endtask

  // Scoreboard: push on input transfer, pop and compare on output transfer.
  always @(negedge clk) begin
    if (!rst) begin
      check_value("in_ready_rule", 32'(in_ready),
                  32'(!((occupancy == 4'(STAGES + 1)) && !out_ready)));
      if (in_valid && in_ready) sb.push_back(cur_exp);
      if (out_valid && out_ready) begin
        delivered++;
        if (sb.size() == 0) begin
          check_value("spurious_out", 32'(out_valid), 32'd0);
        end else begin
          e_mon = sb.pop_front();
          check_value("z", z, e_mon.z);
          check_value("status", 32'(status), 32'(e_mon.st));
          check_value("tag", 32'(out_tag), 32'(e_mon.tag));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_vec(0, 32'h3FC00000, 32'h40000000, 32'h40400000, 8'h00);
    set_vec(1, 32'h7F800000, 32'h00000000, 32'h7FC00000, 8'h04);
    set_vec(2, 32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 8'h30);
    set_vec(3, 32'h00800000, 32'h3F000000, 32'h00400000, 8'h08);
    set_vec(4, 32'h40400000, 32'hC0000000, 32'hC0C00000, 8'h00);
    set_vec(5, 32'h00000000, 32'h3F800000, 32'h00000000, 8'h01);
    set_vec(6, 32'hFF800000, 32'h3F800000, 32'hFF800000, 8'h02);
    set_vec(7, 32'h3F800001, 32'h3F800001, 32'h3F800002, 8'h20);
    set_vec(8, 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 8'h04);
    set_vec(9, 32'h3F800001, 32'h3FC00000, 32'h3FC00002, 8'h20);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_value("rst_out_valid", 32'(out_valid), 32'd0);
    check_value("rst_occupancy", 32'(occupancy), 32'd0);
    check_value("rst_sticky", 32'(sticky), 32'd0);
    check_value("rst_z", z, 32'd0);
    check_value("rst_out_tag", 32'(out_tag), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_value("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Single op and latency
    out_ready = 1'b1;
    send_op(0, 4'd5);
    in_valid = 1'b0;
    cycles = 1;
    while (!out_valid && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
    end
    check_value("latency", 32'(cycles), 32'(STAGES + 1));
    check_value("single_z", z, 32'h40400000);
    check_value("single_tag", 32'(out_tag), 32'd5);
    drain(20);

    // Inf*0 -> nan, sticky nan bit
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    check_value("sticky_cleared", 32'(sticky), 32'd0);
    send_op(1, 4'd1);
    in_valid = 1'b0;
    drain(20);
    check_value("sticky_nan", 32'(sticky), 32'h04);

    // Overflow then all vectors back to back
    for (int i = 0; i < NV; i++) send_op(i, 4'(i + 3));
    in_valid = 1'b0;
    drain(40);

    // Random backpressure stream, tags wrap at 16
    base = delivered;
    prod_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) send_op(i % NV, 4'(i % 16));
        in_valid = 1'b0;
        prod_done = 1'b1;
      end
      begin
        int n = 0;
        while (!(prod_done && sb.size() == 0 && !out_valid) && n < 3000) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
          n++;
        end
      end
    join
    out_ready = 1'b1;
    drain(40);
    check_value("stream_count", 32'(delivered - base), 32'd20);

    // Full pipe stalls and holds outputs
    out_ready = 1'b0;
    for (int k = 0; k <= STAGES; k++) send_op((2 + k) % NV, 4'(7 + k));
    in_valid = 1'b0;
    check_value("full_occupancy", 32'(occupancy), 32'(STAGES + 1));
    check_value("full_in_ready", 32'(in_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_value("hold_z", z, sb[0].z);
      check_value("hold_tag", 32'(out_tag), 32'(sb[0].tag));
      check_value("hold_occupancy", 32'(occupancy), 32'(STAGES + 1));
    end
    // Simultaneous output transfer and input accept
    out_ready = 1'b1;
    send_op(9, 4'd10);
    in_valid = 1'b0;
    check_value("swap_occupancy", 32'(occupancy), 32'(STAGES + 1));
    drain(20);

    // clr_sticky in the same cycle as a nan result transfer
    check_value("sticky_nonzero", 32'(sticky != 8'd0), 32'd1);
    send_op(8, 4'd2);
    in_valid = 1'b0;
    wait_out_valid(20);
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    check_value("sticky_clr_wins", 32'(sticky), 32'd0);
    drain(20);

    // Reset mid-flight
    out_ready = 1'b0;
    send_op(0, 4'd1);
    send_op(4, 4'd2);
    send_op(7, 4'd3);
    in_valid = 1'b0;
    base = delivered;
    #1 rst = 1'b1;
    #1;
    check_value("midrst_out_valid", 32'(out_valid), 32'd0);
    check_value("midrst_occupancy", 32'(occupancy), 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_value("midrst_in_ready", 32'(in_ready), 32'd1);
    repeat (STAGES + 4) @(posedge clk);
    #1;
    check_value("midrst_no_delivery", 32'(delivered - base), 32'd0);
    check_value("midrst_idle", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
